prog_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the instruction memory's load port. It accepts a byte stream (e.g. from a UART receiver) carrying a length header, little-endian 32-bit instruction words and a checksum byte. It assembles the words and writes them into instruction memory through the `lden` / `inst_ld_addr` / `inst_ld_data` path, holding the CPU core in reset until the image is loaded and verified.

---
 rtl/prog_loader.sv | 139 +++++++++++++
 tb/tb_prog_loader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot loader: byte stream (len, LE words, xor checksum) -> instruction memory load port.
// Latency: word written the cycle after its 4th byte is accepted; done one cycle after CHK.
// Backpressure: rx_ready drops in the write cycle and while idle/done/error; bytes are held upstream.
module prog_loader #(
    parameter int          word_width      = 32,
    parameter int          inst_addr_width = 12,
    parameter int unsigned base_addr       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  lden,
    output logic [word_width-1:0] inst_ld_addr,
    output logic [word_width-1:0] inst_ld_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err
);

    // Word capacity of instruction memory, widened so a 16-bit count can exceed it.
    localparam logic [16:0] capacity = 17'(1 << (inst_addr_width - 2));

    typedef enum logic [2:0] {
        IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CHK, DONE, ERROR
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] word_cnt;
    logic [1:0]  byte_cnt;
    logic [23:0] word_buf;
    logic [7:0]  xor_acc;
    logic        accept;
    logic        launch;
    logic [16:0] len_rx;

    assign accept = rx_valid && rx_ready;
    assign len_rx = {1'b0, rx_data, len_lo};
    // A start only counts when the loader is not mid-image.
    assign launch = start && (state == IDLE || state == DONE || state == ERROR);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERROR: if (start) state_nxt = S_LEN_LO;
            S_LEN_LO:          if (accept) state_nxt = S_LEN_HI;
            S_LEN_HI: begin
                if (accept) begin
                    if (len_rx > capacity)   state_nxt = ERROR;
                    else if (len_rx == 17'd0) state_nxt = S_CHK;
                    else                     state_nxt = S_DATA;
                end
            end
            S_DATA:  if (accept && byte_cnt == 2'd3) state_nxt = S_WRITE;
            // word_cnt is bumped this cycle, so compare against the post-write count.
            S_WRITE: state_nxt = (word_cnt + 16'd1 == len) ? S_CHK : S_DATA;
            S_CHK:   if (accept) state_nxt = (rx_data == xor_acc) ? DONE : ERROR;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and registered outputs, all derived from the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_lo       <= '0;
            len          <= '0;
            word_cnt     <= '0;
            byte_cnt     <= '0;
            word_buf     <= '0;
            xor_acc      <= '0;
            rx_ready     <= 1'b0;
            lden         <= 1'b0;
            inst_ld_addr <= '0;
            inst_ld_data <= '0;
            cpu_hold     <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            rx_ready <= (state_nxt == S_LEN_LO) || (state_nxt == S_LEN_HI) ||
                        (state_nxt == S_DATA)   || (state_nxt == S_CHK);
            lden     <= (state_nxt == S_WRITE);

            if (launch) begin
                xor_acc  <= '0;
                word_cnt <= '0;
                byte_cnt <= '0;
                cpu_hold <= 1'b1;
                done     <= 1'b0;
                err      <= 1'b0;
            end

            if (accept && state == S_LEN_LO) begin
                len_lo  <= rx_data;
                xor_acc <= xor_acc ^ rx_data;
            end
            if (accept && state == S_LEN_HI) begin
                len     <= {rx_data, len_lo};
                xor_acc <= xor_acc ^ rx_data;
            end

            if (accept && state == S_DATA) begin
                xor_acc  <= xor_acc ^ rx_data;
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0:    word_buf[7:0]   <= rx_data;
                    2'd1:    word_buf[15:8]  <= rx_data;
                    2'd2:    word_buf[23:16] <= rx_data;
                    default: begin
                        inst_ld_data <= {rx_data, word_buf};
                        inst_ld_addr <= word_width'(base_addr) +
                                        word_width'({word_cnt, 2'b00});
                    end
                endcase
            end

            if (state == S_WRITE)
                word_cnt <= word_cnt + 16'd1;

            if (state != DONE && state_nxt == DONE) begin
                done     <= 1'b1;
                cpu_hold <= 1'b0;
            end
            if (state != ERROR && state_nxt == ERROR)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: scoreboard of expected memory writes.
// Expected words are queued when their bytes are driven; popped on each lden.
// Every byte waits for rx_ready; all waits on the DUT are cycle-bounded.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        lden;
    logic [31:0] inst_ld_addr;
    logic [31:0] inst_ld_data;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    int lden_cnt = 0;
    logic [63:0] sb_q [$];     // {addr, data}
    logic [31:0] img [$];      // words of the image being sent

    prog_loader dut (
        .clk(clk), .reset(reset), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .lden(lden), .inst_ld_addr(inst_ld_addr), .inst_ld_data(inst_ld_data),
        .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Write monitor: every lden must match the oldest expected write, with rx_ready low.
    always @(negedge clk) begin
        if (lden === 1'b1) begin
            logic [63:0] e;
            lden_cnt++;
            check("ready_in_write", {31'd0, rx_ready}, 32'd0);
            if (sb_q.size() == 0) begin
                check("lden_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("ld_addr", inst_ld_addr, e[63:32]);
                check("ld_data", inst_ld_data, e[31:0]);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Offer one byte; it transfers on the first posedge where rx_ready is high.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int cnt = 0;
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 50) check("rx_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    // Send start, header and img; push expected writes; optional mid-load start; CHK xor'ed with flip.
    task automatic load(input bit gaps, input logic [7:0] flip, input bit mid_start);
        logic [7:0]  x = 8'h00;
        logic [15:0] n;
        logic [31:0] w;
        n = 16'(img.size());
        pulse_start();
        check("hold_after_start", {31'd0, cpu_hold}, 32'd1);
        send_byte(n[7:0], gaps);  x ^= n[7:0];
        send_byte(n[15:8], gaps); x ^= n[15:8];
        for (int k = 0; k < img.size(); k++) begin
            w = img[k];
            sb_q.push_back({32'(k * 4), w});
            for (int j = 0; j < 4; j++) begin
                send_byte(w[8*j +: 8], gaps);
                x ^= w[8*j +: 8];
                if (mid_start && k == 0 && j == 1) pulse_start();
            end
        end
        send_byte(x ^ flip, gaps);
    endtask

    task automatic wait_end(input string tag, input bit exp_done, input int exp_lden);
        int cnt = 0;
        while (!(done || err) && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 50) check({tag, "_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
        check({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
        check({tag, "_err"},  {31'd0, err},  {31'd0, !exp_done});
        check({tag, "_hold"}, {31'd0, cpu_hold}, {31'd0, !exp_done});
        check({tag, "_ready"}, {31'd0, rx_ready}, 32'd0);
        check({tag, "_lden_cnt"}, 32'(lden_cnt), 32'(exp_lden));
        check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
        lden_cnt = 0;
        sb_q.delete();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, rx_ready}, 32'd0);
        check("rst_lden",  {31'd0, lden}, 32'd0);
        check("rst_addr",  inst_ld_addr, 32'd0);
        check("rst_data",  inst_ld_data, 32'd0);
        check("rst_hold",  {31'd0, cpu_hold}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_err",   {31'd0, err}, 32'd0);
        reset = 1'b0;

        // Single word 0x00A00513, good checksum (B7).
        img = '{32'h00A00513};
        load(1'b0, 8'h00, 1'b0);
        wait_end("one_word", 1'b1, 1);

        // Three random words with random valid gaps.
        img = '{$urandom, $urandom, $urandom};
        load(1'b1, 8'h00, 1'b0);
        wait_end("three_word", 1'b1, 3);

        // Bad checksum: word still written, then error.
        img = '{32'h00A00513};
        load(1'b0, 8'h01, 1'b0);
        wait_end("bad_chk", 1'b0, 1);

        // Overflow: N = 1025 exceeds 1024-word capacity.
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h04, 1'b0);
        wait_end("overflow", 1'b0, 0);

        // Empty image: header 00 00 then CHK 00.
        img.delete();
        load(1'b0, 8'h00, 1'b0);
        wait_end("empty", 1'b1, 0);

        // Mid-load start must be ignored.
        img = '{32'h12345678, 32'h9ABCDEF0};
        load(1'b0, 8'h00, 1'b1);
        wait_end("mid_start", 1'b1, 2);

        // Reset after two data bytes of the first word.
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        check("midrst_lden",  {31'd0, lden}, 32'd0);
        check("midrst_ready", {31'd0, rx_ready}, 32'd0);
        check("midrst_hold",  {31'd0, cpu_hold}, 32'd0);
        check("midrst_done",  {31'd0, done}, 32'd0);
        check("midrst_err",   {31'd0, err}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_idle_ready", {31'd0, rx_ready}, 32'd0);
        check("midrst_no_lden", 32'(lden_cnt), 32'd0);

        img = '{32'hDEADBEEF};
        load(1'b0, 8'h00, 1'b0);
        wait_end("after_rst", 1'b1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
